// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - shared types and helpers for the approximate pipelined adder
// Purpose: mode encoding, per-stage control payload, segment width helper.
// Ports: none (package).
package approx_adder_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Control part of a stage payload; the partial sum and the operands
    // travel alongside it as WIDTH-bit vectors sized by the stage module.
    typedef struct packed {
        logic valid;
        logic mode;
        logic carry;
    } stage_ctrl_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/approx_pipe_adder_if.sv
// rtl/approx_pipe_adder_if.sv - handshake bundle for approx_pipe_adder
// Purpose: groups the input/output valid-ready streams, operands and result.
// Ports: in_valid/in_ready/a/b/cin/mode (input side), out_valid/out_ready/s/cout
//        (output side); with APPROX_ERR_STATS_EN also clr_stats/err_count/err_sum.
interface approx_pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef APPROX_ERR_STATS_EN
    logic              clr_stats;
    logic [31:0]       err_count;
    logic [WIDTH+16:0] err_sum;

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready, clr_stats,
        output in_ready, out_valid, s, cout, err_count, err_sum
    );
    modport master (
        output in_valid, a, b, cin, mode, out_ready, clr_stats,
        input  in_ready, out_valid, s, cout, err_count, err_sum
    );
`else
    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, s, cout
    );
    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, s, cout
    );
`endif
endinterface

// File: rtl/approx_pipe_adder_stage.sv
// rtl/approx_pipe_adder_stage.sv - one carry-chain segment plus its pipeline register
// Purpose: adds bits [IDX*SW +: SW] using the carry from the previous stage,
//          applying the lower-part OR approximation to bits below APPROX_BITS.
// Ports: clk, rst; d_ctrl/d_sum/d_a/d_b payload in; next_load (downstream loads);
//        load (this stage loads); q_ctrl/q_sum/q_a/q_b registered payload out.
module approx_pipe_stage
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 1,
    parameter int STAGES      = 2,
    parameter int IDX         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ctrl_t      d_ctrl,
    input  logic [WIDTH-1:0] d_sum,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic             next_load,
    output logic             load,
    output stage_ctrl_t      q_ctrl,
    output logic [WIDTH-1:0] q_sum,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b
);
    localparam int SW = seg_width(WIDTH, STAGES);
    localparam int LO = IDX * SW;

    logic [WIDTH-1:0] nx_sum;
    logic             nx_carry;

    always_comb begin
        nx_sum   = d_sum;
        nx_carry = d_ctrl.carry;
        for (int j = 0; j < SW; j++) begin
            if (d_ctrl.mode == MODE_APPROX && (LO + j) < APPROX_BITS) begin
                // OR bit; only the top approximate bit's AND survives as the
                // carry into bit APPROX_BITS, lower ones are overwritten.
                nx_sum[LO+j] = d_a[LO+j] | d_b[LO+j];
                nx_carry     = d_a[LO+j] & d_b[LO+j];
            end else begin
                nx_sum[LO+j] = d_a[LO+j] ^ d_b[LO+j] ^ nx_carry;
                nx_carry     = (d_a[LO+j] & d_b[LO+j]) | (nx_carry & (d_a[LO+j] ^ d_b[LO+j]));
            end
        end
    end

    // Bubble-collapsing: an empty stage always accepts.
    assign load = !q_ctrl.valid || next_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_ctrl <= '0;
            q_sum  <= '0;
            q_a    <= '0;
            q_b    <= '0;
        end else if (load) begin
            q_ctrl <= '{valid: d_ctrl.valid, mode: d_ctrl.mode, carry: nx_carry};
            q_sum  <= nx_sum;
            q_a    <= d_a;
            q_b    <= d_b;
        end
    end

endmodule

// File: rtl/approx_pipe_adder.sv
// rtl/approx_pipe_adder.sv - pipelined adder with runtime lower-part OR approximation
// Purpose: WIDTH-bit adder split into STAGES carry segments, valid/ready on both sides,
//          per-transaction exact/approximate mode. Optional macro APPROX_ERR_STATS_EN
//          adds error statistics against a shadow exact sum.
// Ports: clk, rst (async, active-high); bus (approx_pipe_adder_if.slave).
module approx_pipe_adder
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 1,
    parameter int STAGES      = 2
) (
    input logic                clk,
    input logic                rst,
    approx_pipe_adder_if.slave bus
);
    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("approx_pipe_adder: WIDTH must be a multiple of STAGES");
    end
    if (APPROX_BITS < 0 || APPROX_BITS >= WIDTH) begin : g_bad_approx
        $error("approx_pipe_adder: APPROX_BITS must be in 0..WIDTH-1");
    end

    // Index 0 is the input port; index k+1 is the register of stage k.
    stage_ctrl_t      ctrl [STAGES+1];
    logic [WIDTH-1:0] sm   [STAGES+1];
    logic [WIDTH-1:0] oa   [STAGES+1];
    logic [WIDTH-1:0] ob   [STAGES+1];
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] nl;

    assign ctrl[0] = '{valid: bus.in_valid, mode: bus.mode, carry: bus.cin};
    assign sm[0]   = '0;
    assign oa[0]   = bus.a;
    assign ob[0]   = bus.b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == STAGES - 1) begin : g_last
            assign nl[k] = bus.out_ready;
        end else begin : g_mid
            assign nl[k] = ld[k+1];
        end

        approx_pipe_stage #(
            .WIDTH      (WIDTH),
            .APPROX_BITS(APPROX_BITS),
            .STAGES     (STAGES),
            .IDX        (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .d_ctrl   (ctrl[k]),
            .d_sum    (sm[k]),
            .d_a      (oa[k]),
            .d_b      (ob[k]),
            .next_load(nl[k]),
            .load     (ld[k]),
            .q_ctrl   (ctrl[k+1]),
            .q_sum    (sm[k+1]),
            .q_a      (oa[k+1]),
            .q_b      (ob[k+1])
        );
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = ctrl[STAGES].valid;
    assign bus.s         = sm[STAGES];
    assign bus.cout      = ctrl[STAGES].carry;

    // Operands are fully consumed once they leave the last stage.
    logic unused_tail;
    assign unused_tail = ^{oa[STAGES], ob[STAGES], ctrl[STAGES].mode};

`ifdef APPROX_ERR_STATS_EN
    logic [WIDTH:0] ex [STAGES+1];

    assign ex[0] = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};

    for (genvar k = 0; k < STAGES; k++) begin : g_shadow
        logic [WIDTH:0] r;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r <= '0;
            end else if (ld[k]) begin
                r <= ex[k];
            end
        end
        assign ex[k+1] = r;
    end

    logic [WIDTH:0]    apx;
    logic [WIDTH:0]    diff;
    logic              err_hit;
    logic [WIDTH+17:0] sum_nx;
    logic [31:0]       cnt_q;
    logic [WIDTH+16:0] acc_q;

    assign apx     = {ctrl[STAGES].carry, sm[STAGES]};
    assign diff    = (ex[STAGES] > apx) ? ex[STAGES] - apx : apx - ex[STAGES];
    assign err_hit = bus.out_valid && bus.out_ready
                     && ctrl[STAGES].mode == MODE_APPROX && apx != ex[STAGES];
    assign sum_nx  = {1'b0, acc_q} + {17'b0, diff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (bus.clr_stats) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (err_hit) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
            acc_q <= sum_nx[WIDTH+17] ? '1 : sum_nx[WIDTH+16:0];
        end
    end

    assign bus.err_count = cnt_q;
    assign bus.err_sum   = acc_q;
`endif

endmodule

// File: tb/tb_approx_pipe_adder.sv
// tb/tb_approx_pipe_adder.sv - self-checking bench for approx_pipe_adder
module tb_approx_pipe_adder;
    localparam int WIDTH  = 8;
    localparam int N      = 1;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    approx_pipe_adder #(
        .WIDTH      (WIDTH),
        .APPROX_BITS(N),
        .STAGES     (STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [WIDTH:0] exp_q[$];
    logic          held_valid = 1'b0;
    logic [WIDTH:0] held_val;
    logic [WIDTH:0] last_out;
    logic          seen_out;
    int            accepts;
    int            stalls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: arithmetic on integers straight from the add rules.
    function automatic logic [WIDTH:0] ref_add(input int a, input int b, input int c, input int m);
        int lo, hi, mask;
        if (m == 1 && N > 0) begin
            mask = (1 << N) - 1;
            lo   = (a | b) & mask;
            hi   = (a >> N) + (b >> N) + ((a >> (N - 1)) & (b >> (N - 1)) & 1);
            return (WIDTH+1)'((hi << N) | lo);
        end
        return (WIDTH+1)'(a + b + c);
    endfunction

    task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic im, input logic ordy);
        logic [WIDTH:0] e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = ic;
        bus.mode      = im;
        bus.out_ready = ordy;
        #1;
        if (held_valid) begin
            check("stall_hold_valid", bus.out_valid, 1);
            check("stall_hold_result", {bus.cout, bus.s}, held_val);
        end
        if (bus.out_valid && bus.out_ready) begin
            check("expected_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result", {bus.cout, bus.s}, e);
            end
            seen_out = 1'b1;
            last_out = {bus.cout, bus.s};
        end
        held_valid = bus.out_valid && !bus.out_ready;
        held_val   = {bus.cout, bus.s};
        if (iv && bus.in_ready) begin
            exp_q.push_back(ref_add(int'(ia), int'(ib), int'(ic), int'(im)));
            accepts++;
        end else if (iv) begin
            stalls++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (exp_q.size() != 0 || bus.out_valid); i++)
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_directed(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                input logic ic, input logic im, input logic [WIDTH:0] want);
        int lat;
        drain();
        step(1'b1, ia, ib, ic, im, 1'b1);
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            seen_out = 1'b0;
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (seen_out) lat = n;
        end
        check({tag, "_latency"}, lat, STAGES);
        check(tag, last_out, want);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
`ifdef APPROX_ERR_STATS_EN
        bus.clr_stats = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_s", bus.s, 0);
        check("reset_cout", bus.cout, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_in_ready", bus.in_ready, 1);

        run_directed("apx_03_01", 8'h03, 8'h01, 1'b0, 1'b1, 9'h005);
        run_directed("ex_03_01",  8'h03, 8'h01, 1'b0, 1'b0, 9'h004);
        run_directed("ex_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        run_directed("apx_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1, 9'h101);
        run_directed("apx_cin_ignored", 8'h02, 8'h04, 1'b1, 1'b1, 9'h006);
        run_directed("ex_wrap_cin", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);

        // Back-to-back sweep, no backpressure: every cycle must accept.
        accepts = 0;
        stalls  = 0;
        for (int a = 0; a < 256; a += 5)
            for (int b = 0; b < 256; b += 7)
                for (int c = 0; c < 2; c++)
                    for (int m = 0; m < 2; m++)
                        step(1'b1, WIDTH'(a), WIDTH'(b), 1'(c), 1'(m), 1'b1);
        check("sweep_bubbles", stalls, 0);
        check("sweep_accepts", accepts, 52 * 37 * 4);
        drain();

        // Random valid and backpressure.
        accepts = 0;
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        check("random_some_accepted", accepts > 500, 1);

        // Reset with two transactions in flight.
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_s", bus.s, 0);
        check("midrst_cout", bus.cout, 0);
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_no_output", bus.out_valid, 0);
        run_directed("post_rst", 8'h7F, 8'h01, 1'b1, 1'b0, 9'h081);

`ifdef APPROX_ERR_STATS_EN
        drain();
        @(negedge clk);
        bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.clr_stats = 1'b0;
        #1;
        check("stats_clr_count", bus.err_count, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h03, 8'h01, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1);
        drain();
        check("stats_err_count", bus.err_count, 3);
        check("stats_err_sum", bus.err_sum, 3);
        @(negedge clk);
        bus.clr_stats = 1'b1;
        @(negedge clk);
        #1;
        check("stats_cleared_count", bus.err_count, 0);
        check("stats_cleared_sum", bus.err_sum, 0);
        bus.clr_stats = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
